// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/halfword/word load-store unit in front of a one-cycle-latency 32-bit word RAM
module mem_access_unit #(
  parameter int RAM_WORDS = 32768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        ram_wren,
  output logic [29:0] ram_address,
  output logic [31:0] ram_data,
  output logic [3:0]  ram_byteena,
  input  logic [31:0] ram_q
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t state, state_n;
  logic we_q, sgn_q, err_q, acc, bad;
  logic [1:0] size_q, off_q;
  logic [3:0] be_q, be_n;
  logic [31:0] rdata_q, lane, ext;
  assign req_ready = state == IDLE;
  assign acc = req_valid && req_ready;
  assign bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
               {2'b00, req_addr[31:2]} >= 32'(RAM_WORDS);
  assign be_n = req_size == 2'b00 ? 4'b0001 << req_addr[1:0] :
                req_size == 2'b01 ? 4'b0011 << req_addr[1:0] : 4'b1111;
  assign lane = ram_q >> {off_q, 3'b000};
  assign ext = size_q == 2'b00 ? {{24{sgn_q & lane[7]}}, lane[7:0]} :
               size_q == 2'b01 ? {{16{sgn_q & lane[15]}}, lane[15:0]} : ram_q;
  assign resp_valid = state == RESP;
  assign resp_err = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign ram_wren = state == ISSUE && we_q;
  assign ram_byteena = state == ISSUE ? be_q : 4'b0000;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = acc ? (bad ? RESP : ISSUE) : IDLE;
      ISSUE:   state_n = we_q ? RESP : CAPTURE;
      CAPTURE: state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      we_q <= 1'b0;
      sgn_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= 2'b00;
      off_q <= 2'b00;
      be_q <= 4'b0000;
      rdata_q <= 32'h0;
      ram_address <= 30'h0;
      ram_data <= 32'h0;
    end else begin
      state <= state_n;
      if (acc) begin
        we_q <= req_we;
        sgn_q <= req_signed;
        err_q <= bad;
        size_q <= req_size;
        off_q <= req_addr[1:0];
        be_q <= be_n;
        rdata_q <= 32'h0;
        if (!bad) begin
          ram_address <= req_addr[31:2];
          ram_data <= req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                      req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
        end
      end
      if (state == CAPTURE) rdata_q <= ext;
    end
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter RAM_WORDS, default 32768, number of 32-bit words behind the RAM port; word addresses at or above it are out of range.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  requester presents an access.
REQ-005 req_ready  output  1  unit can accept; high only in IDLE.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_signed  input  1  sign-extend loaded byte/halfword.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle pulse marking completion.
REQ-012 resp_rdata  output  32  load result, valid with resp_valid.
REQ-013 resp_err  output  1  access rejected, valid with resp_valid.
REQ-014 ram_wren  output  1  RAM write enable.
REQ-015 ram_address  output  30  RAM word address.
REQ-016 ram_data  output  32  RAM write data, lane-replicated.
REQ-017 ram_byteena  output  4  RAM byte enables; bit n covers data bits 8n+7:8n.
REQ-018 ram_q  input  32  RAM read data, valid from the cycle after the edge that samples ram_address.

Function
REQ-019 The unit SHALL use FSM states IDLE, ISSUE, CAPTURE and RESP.
REQ-020 Acceptance SHALL occur on an edge where req_valid and req_ready are both high; all req_* fields are registered at that edge.
REQ-021 An access SHALL be rejected if: req_size=11; halfword with addr[0]=1; word with addr[1:0]!=00; or addr[31:2] >= RAM_WORDS.
REQ-022 On acceptance, a rejected access SHALL go IDLE->RESP with no RAM activity; resp_err=1 and resp_rdata=0.
REQ-023 On acceptance, a legal access SHALL go IDLE->ISSUE, with ram_address=addr[31:2] registered.
REQ-024 Lane offset off=addr[1:0] SHALL be used; little-endian byte lanes.
REQ-025 ram_byteena SHALL be: byte 0001<<off; halfword 0011<<off; word 1111.
REQ-026 ram_data SHALL be: byte {4{wdata[7:0]}}; halfword {2{wdata[15:0]}}; word wdata.
REQ-027 ram_wren SHALL be high only during ISSUE of a store; it is exactly one cycle long.
REQ-028 Store: ISSUE->RESP; resp_valid rises 2 cycles after the accept edge, with resp_rdata=0 and resp_err=0.
REQ-029 Load: ISSUE->CAPTURE->RESP; at the CAPTURE-exit edge the unit SHALL latch the extracted ram_q lane; resp_valid rises 3 cycles after the accept edge.
REQ-030 Load extraction: byte = ram_q[8*off+7:8*off]; halfword = ram_q[8*off+15:8*off].
REQ-031 Load extension: zero-extend to 32 bits if req_signed=0, sign-extend if req_signed=1; req_signed is ignored for words.
REQ-032 RESP SHALL last exactly one cycle, then return to IDLE; back-to-back accesses are 1 idle cycle apart minimum.
REQ-033 req_ready SHALL be 0 in ISSUE, CAPTURE and RESP; requests held high then are not accepted and not lost (accepted on return to IDLE).
REQ-034 Outside ISSUE, ram_byteena SHALL be 0000 and ram_wren 0; ram_address and ram_data hold their last values.
REQ-035 A load issued after a store response SHALL return the stored data (RAM write commits at the ISSUE-exit edge).

Reset
REQ-036 While rst is high at an edge, the unit SHALL enter IDLE with req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, ram_wren=0, ram_byteena=0, ram_address=0 and ram_data=0.
REQ-037 If rst asserts mid-operation, the in-flight access SHALL produce no response.
REQ-038 A store in ISSUE at the reset edge commits in the RAM; the unit need not prevent it.

Verification
REQ-039 Store word 0xDEADBEEF to 0x10, then load word from 0x10 -> store: wren pulse, ram_address=4, byteena=1111; load: resp_rdata=0xDEADBEEF, resp_valid 3 cycles after accept.
REQ-040 Store byte 0x80 at 0x13, then load byte from 0x13 -> store: byteena=1000, ram_data=0x80808080; signed load returns 0xFFFFFF80; unsigned load returns 0x00000080.
REQ-041 Load halfword from 0x12 over word 0x8001_1234, signed -> 0xFFFF8001; load halfword from 0x10 unsigned -> 0x00001234.
REQ-042 Halfword at 0x11, word at 0x12, size=11, word at 4*RAM_WORDS -> each: resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept, ram_wren never high.
REQ-043 req_valid held high continuously with alternating stores/loads -> req_ready low in ISSUE/CAPTURE/RESP, no request dropped or duplicated, results correct.
REQ-044 rst asserted during CAPTURE of a load -> no resp_valid; next cycle all outputs at reset values, req_ready=1; a following access completes normally.
